// File: rtl/pipe_perf_pkg.sv
// Shared types for the pipeline performance monitor.
// FSM states and overflow-flag bit positions.
package pipe_perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TRIPPED = 2'd3
    } state_e;

    localparam int OVF_CYC  = 0;
    localparam int OVF_INSN = 1;
    localparam int OVF_CTRL = 2;
    localparam int OVF_MISP = 3;
    localparam int OVF_EVT0 = 4;

endpackage

// File: rtl/perf_counter.sv
// One event counter with wrap/saturate overflow handling,
// a sticky overflow flag and its own snapshot register.
module perf_counter #(
    parameter int W        = 32,
    parameter int SAT_MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic         snap,
    output logic [W-1:0] count,
    output logic         ovf
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         full;

    assign full = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            if (full && SAT_MODE != 0) cnt_d = cnt_q;
            else                       cnt_d = cnt_q + 1'b1;
        end
    end

    // snapshot takes the post-increment value of this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (inc && full) ovf <= 1'b1;
            if (snap) count <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Retire-side performance counters, stall watchdog and
// self-loop halt detector with a coherent snapshot set.
module pipe_perf_monitor
    import pipe_perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int NEVT     = 4,
    parameter int SAT_MODE = 0,
    parameter int WDOG_CYC = 1024,
    parameter int HALT_REP = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic                  i_snap,
    input  logic                  i_insn_vld,
    input  logic                  i_mispred,
    input  logic                  i_ctrl,
    input  logic [31:0]           i_pc,
    input  logic [NEVT-1:0]       i_evt,
    output logic [CNT_W-1:0]      o_cycle_cnt,
    output logic [CNT_W-1:0]      o_insn_cnt,
    output logic [CNT_W-1:0]      o_ctrl_cnt,
    output logic [CNT_W-1:0]      o_mispred_cnt,
    output logic [NEVT*CNT_W-1:0] o_evt_cnt,
    output logic [4+NEVT-1:0]     o_ovf,
    output logic                  o_snap_vld,
    output logic                  o_wdog_trip,
    output logic                  o_halt,
    output logic [1:0]            o_state
);

    localparam int NCNT = 4 + NEVT;
    localparam int SW   = $clog2(WDOG_CYC + 1);
    localparam int RW   = $clog2(HALT_REP + 1);

    state_e           state;
    logic             cnt_en;
    logic [NCNT-1:0]  inc;
    logic [CNT_W-1:0] snap_cnt [NCNT];
    logic [SW-1:0]    stall;
    logic [SW-1:0]    stall_nxt;
    logic [RW-1:0]    rep;
    logic [RW-1:0]    rep_nxt;
    logic [31:0]      last_pc;
    logic             pc_hit;
    logic             halt_hit;
    logic             wdog_hit;

    assign cnt_en = (state == RUN) && i_en;

    assign inc[OVF_CYC]  = cnt_en;
    assign inc[OVF_INSN] = cnt_en & i_insn_vld;
    assign inc[OVF_CTRL] = cnt_en & i_insn_vld & i_ctrl;
    assign inc[OVF_MISP] = cnt_en & i_insn_vld & i_mispred;
    assign inc[OVF_EVT0 +: NEVT] = {NEVT{cnt_en}} & i_evt;

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        perf_counter #(
            .W        (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cnt (
            .clk   (i_clk),
            .rst_n (i_reset),
            .inc   (inc[g]),
            .clr   (i_clear),
            .snap  (i_snap),
            .count (snap_cnt[g]),
            .ovf   (o_ovf[g])
        );
    end

    assign o_cycle_cnt   = snap_cnt[OVF_CYC];
    assign o_insn_cnt    = snap_cnt[OVF_INSN];
    assign o_ctrl_cnt    = snap_cnt[OVF_CTRL];
    assign o_mispred_cnt = snap_cnt[OVF_MISP];

    for (genvar k = 0; k < NEVT; k++) begin : g_evt
        assign o_evt_cnt[k*CNT_W +: CNT_W] = snap_cnt[OVF_EVT0+k];
    end

    assign stall_nxt = stall + 1'b1;
    assign rep_nxt   = rep + 1'b1;
    assign pc_hit    = (i_pc == last_pc);
    assign halt_hit  = pc_hit && (rep_nxt == RW'(HALT_REP));
    assign wdog_hit  = (stall_nxt == SW'(WDOG_CYC));
    assign o_state   = state;

    // halt needs a retirement and the watchdog needs none,
    // so the two can never fire together
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            stall       <= '0;
            rep         <= '0;
            last_pc     <= '0;
            o_wdog_trip <= 1'b0;
            o_halt      <= 1'b0;
            o_snap_vld  <= 1'b0;
        end else begin
            o_snap_vld <= i_snap;
            if (i_clear) begin
                state       <= IDLE;
                stall       <= '0;
                rep         <= '0;
                last_pc     <= '0;
                o_wdog_trip <= 1'b0;
                o_halt      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (i_en) state <= RUN;
                    RUN: if (cnt_en) begin
                        if (i_insn_vld) begin
                            stall <= '0;
                            if (pc_hit) begin
                                rep <= rep_nxt;
                            end else begin
                                rep     <= RW'(1);
                                last_pc <= i_pc;
                            end
                            if (halt_hit) begin
                                state  <= HALTED;
                                o_halt <= 1'b1;
                            end
                        end else begin
                            stall <= stall_nxt;
                            if (wdog_hit) begin
                                state       <= TRIPPED;
                                o_wdog_trip <= 1'b1;
                            end
                        end
                    end
                    HALTED, TRIPPED: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: counting, overflow,
// watchdog, halt, clear/snap priority and async reset.
module tb_pipe_perf_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, snap, vld, misp, ctrl;
    logic [31:0] pc;
    logic [3:0]  evt;

    logic [31:0] m_cyc, m_insn, m_ctrl, m_misp;
    logic [127:0] m_evt;
    logic [7:0]  m_ovf;
    logic        m_sv, m_trip, m_halt;
    logic [1:0]  m_st;

    logic [3:0]  w_cyc, w_insn, w_ctrl, w_misp;
    logic [15:0] w_evt;
    logic [7:0]  w_ovf;
    logic        w_sv, w_trip, w_halt;
    logic [1:0]  w_st;

    logic [3:0]  s_cyc, s_insn, s_ctrl, s_misp;
    logic [15:0] s_evt;
    logic [7:0]  s_ovf;
    logic        s_sv, s_trip, s_halt;
    logic [1:0]  s_st;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(
        .CNT_W(32), .NEVT(4), .SAT_MODE(0),
        .WDOG_CYC(16), .HALT_REP(8)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_en(en),
        .i_clear(clr), .i_snap(snap), .i_insn_vld(vld),
        .i_mispred(misp), .i_ctrl(ctrl), .i_pc(pc),
        .i_evt(evt), .o_cycle_cnt(m_cyc),
        .o_insn_cnt(m_insn), .o_ctrl_cnt(m_ctrl),
        .o_mispred_cnt(m_misp), .o_evt_cnt(m_evt),
        .o_ovf(m_ovf), .o_snap_vld(m_sv),
        .o_wdog_trip(m_trip), .o_halt(m_halt),
        .o_state(m_st)
    );

    pipe_perf_monitor #(
        .CNT_W(4), .NEVT(4), .SAT_MODE(0),
        .WDOG_CYC(1024), .HALT_REP(8)
    ) dut_w (
        .i_clk(clk), .i_reset(rst_n), .i_en(en),
        .i_clear(clr), .i_snap(snap), .i_insn_vld(vld),
        .i_mispred(misp), .i_ctrl(ctrl), .i_pc(pc),
        .i_evt(evt), .o_cycle_cnt(w_cyc),
        .o_insn_cnt(w_insn), .o_ctrl_cnt(w_ctrl),
        .o_mispred_cnt(w_misp), .o_evt_cnt(w_evt),
        .o_ovf(w_ovf), .o_snap_vld(w_sv),
        .o_wdog_trip(w_trip), .o_halt(w_halt),
        .o_state(w_st)
    );

    pipe_perf_monitor #(
        .CNT_W(4), .NEVT(4), .SAT_MODE(1),
        .WDOG_CYC(1024), .HALT_REP(8)
    ) dut_s (
        .i_clk(clk), .i_reset(rst_n), .i_en(en),
        .i_clear(clr), .i_snap(snap), .i_insn_vld(vld),
        .i_mispred(misp), .i_ctrl(ctrl), .i_pc(pc),
        .i_evt(evt), .o_cycle_cnt(s_cyc),
        .o_insn_cnt(s_insn), .o_ctrl_cnt(s_ctrl),
        .o_mispred_cnt(s_misp), .o_evt_cnt(s_evt),
        .o_ovf(s_ovf), .o_snap_vld(s_sv),
        .o_wdog_trip(s_trip), .o_halt(s_halt),
        .o_state(s_st)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; clr = 0; snap = 0; vld = 0;
        misp = 0; ctrl = 0; pc = '0; evt = '0;
        #12;
        check("rst_state", 64'(m_st), 0);
        check("rst_ovf", 64'(m_ovf), 0);
        check("rst_halt", 64'(m_halt), 0);
        check("rst_cyc", 64'(m_cyc), 0);
        rst_n = 1'b1;
        tick();

        // basic counting: entry cycle does not count
        en = 1;
        tick();
        check("run_state", 64'(m_st), 1);
        for (int i = 0; i < 10; i++) begin
            vld  = 1;
            pc   = 32'h1000 + 32'(4 * i);
            ctrl = (i == 2 || i == 5 || i == 7);
            misp = (i == 5);
            evt  = {1'b0, (i < 3), 1'b0, 1'b1};
            snap = (i == 9);
            tick();
            if (i == 8) begin
                check("pre_snap_cyc", 64'(m_cyc), 0);
                check("pre_snap_vld", 64'(m_sv), 0);
            end
        end
        en = 0; vld = 0; ctrl = 0; misp = 0;
        evt = '0; snap = 0;
        check("snap_vld", 64'(m_sv), 1);
        check("cyc10", 64'(m_cyc), 10);
        check("insn10", 64'(m_insn), 10);
        check("ctrl3", 64'(m_ctrl), 3);
        check("misp1", 64'(m_misp), 1);
        check("evt0", 64'(m_evt[31:0]), 10);
        check("evt2", 64'(m_evt[95:64]), 3);
        tick();
        check("snap_vld_fall", 64'(m_sv), 0);
        check("snap_stable", 64'(m_cyc), 10);

        // overflow: 17 counting cycles total
        en = 1;
        for (int i = 0; i < 7; i++) begin
            vld  = 1;
            pc   = 32'h2000 + 32'(4 * i);
            snap = (i == 6);
            tick();
        end
        en = 0; vld = 0; snap = 0;
        check("m_cyc17", 64'(m_cyc), 17);
        check("m_ovf0", 64'(m_ovf), 0);
        check("w_cyc_wrap", 64'(w_cyc), 1);
        check("w_ovf", 64'(w_ovf), 64'h03);
        check("s_cyc_sat", 64'(s_cyc), 15);
        check("s_insn_sat", 64'(s_insn), 15);
        check("s_ovf", 64'(s_ovf), 64'h03);

        // clear beats snap; snapshot zeroed, pulse still issued
        clr = 1; snap = 1;
        tick();
        clr = 0; snap = 0;
        check("clr_snap_vld", 64'(m_sv), 1);
        check("clr_cyc", 64'(m_cyc), 0);
        check("clr_insn", 64'(m_insn), 0);
        check("clr_state", 64'(m_st), 0);
        check("clr_w_ovf", 64'(w_ovf), 0);
        check("clr_w_cyc", 64'(w_cyc), 0);

        // watchdog
        en = 1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                check("wd15_trip", 64'(m_trip), 0);
                check("wd15_state", 64'(m_st), 1);
            end
        end
        check("wd_trip", 64'(m_trip), 1);
        check("wd_state", 64'(m_st), 3);
        tick();
        tick();
        snap = 1;
        tick();
        snap = 0;
        check("wd_frozen_cyc", 64'(m_cyc), 16);
        check("wd_insn", 64'(m_insn), 0);
        check("wd_state_hold", 64'(m_st), 3);

        // halt detection
        en = 0; clr = 1;
        tick();
        clr = 0; en = 1;
        tick();
        vld = 1; pc = 32'h100;
        repeat (7) tick();
        pc = 32'h104;
        tick();
        check("seven_no_halt", 64'(m_halt), 0);
        check("seven_state", 64'(m_st), 1);
        pc = 32'h100;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("rep7_halt", 64'(m_halt), 0);
        end
        check("halt", 64'(m_halt), 1);
        check("halt_state", 64'(m_st), 2);
        snap = 1;
        tick();
        snap = 0; vld = 0;
        check("halt_insn", 64'(m_insn), 16);
        check("halt_cyc", 64'(m_cyc), 16);
        check("halt_no_trip", 64'(m_trip), 0);

        // async reset mid-RUN
        en = 0; clr = 1;
        tick();
        clr = 0; en = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            vld  = 1;
            pc   = 32'h3000 + 32'(4 * i);
            snap = (i == 2);
            tick();
        end
        vld = 0; snap = 0;
        check("pre_rst_cyc", 64'(m_cyc), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 64'(m_st), 0);
        check("arst_cyc", 64'(m_cyc), 0);
        check("arst_sv", 64'(m_sv), 0);
        check("arst_insn", 64'(m_insn), 0);
        en = 0;
        rst_n = 1'b1;
        repeat (3) tick();
        snap = 1;
        tick();
        snap = 0;
        check("post_rst_cyc", 64'(m_cyc), 0);
        check("post_rst_state", 64'(m_st), 0);
        en = 1;
        tick();
        snap = 1;
        tick();
        snap = 0;
        check("rerun_state", 64'(m_st), 1);
        check("rerun_cyc", 64'(m_cyc), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
